pc_gen: RTL and testbench
=========================

// Module: pc_gen
// PURPOSE
//   Parametrised fetch-address generator at the head of the IF stage; successor to the basic PC register.
//   Adds a programmable reset vector and a handshake with instruction memory (inst_req / inst_addr_ok_i).
//   Adds prioritised redirects: flush/exception over branch over sequential.
//   A redirect that arrives while the PC cannot advance is held in a pending buffer, not dropped.
// PARAMETERS
//   ADDR_W        32            width of pc and all target addresses
//   RESET_VECTOR  32'hbfc00000  first fetch address after reset (ADDR_W bits)
//   INST_BYTES    4             sequential increment in bytes (power of two)
//   STALL_W       6             width of the pipeline stall vector; bit 0 belongs to this stage
// PORTS
//   clk              in   1        clock, rising edge
//   rst              in   1        asynchronous, active-low reset (0 = reset)
//   stall            in   STALL_W  pipeline stall vector; stall[0]=1 holds pc
//   flush_i          in   1        exception/eret redirect, highest priority
//   new_pc_i         in   ADDR_W   target for flush_i
//   branch_flag_i    in   1        taken branch from ID
//   branch_target_i  in   ADDR_W   target for branch_flag_i
//   inst_addr_ok_i   in   1        instruction memory accepted current inst_req/pc
//   pc               out  ADDR_W   current fetch address
//   ce               out  1        fetch enable (chip enable)
//   inst_req         out  1        fetch request valid; pc is stable while inst_req=1 and !inst_addr_ok_i
// BEHAVIOUR
//   Reset (rst=0, async): pc=RESET_VECTOR, ce=0, inst_req=0, pend_vld=0, state=BOOT.
//   FSM: BOOT -> RUN on the first clk edge after reset release; RUN stays until reset.
//     BOOT: ce=0, inst_req=0; pc holds RESET_VECTOR.
//     RUN: ce=1; inst_req=1 unless stall[0]=1.
//   First request is RESET_VECTOR, in the cycle after BOOT.
//   adv = state==RUN && !stall[0] && inst_addr_ok_i.
//   Next-pc priority, applied only when adv=1:
//     1. flush_i -> new_pc_i
//     2. pend_vld -> pend_pc
//     3. branch_flag_i -> branch_target_i
//     4. otherwise pc + INST_BYTES (modulo 2^ADDR_W; wraps silently)
//   Same-cycle flush_i and branch_flag_i: flush wins; the branch is discarded.
//   Pending buffer (pend_vld, pend_pc, pend_is_flush):
//     - redirect seen when adv=0 and state==RUN -> captured, pend_vld=1.
//     - flush captured overwrites any pending entry.
//     - branch captured only if no pending flush; it overwrites a pending branch.
//     - cleared when adv=1, after which pc = the chosen target.
//     - flush_i with adv=1 also clears pending: the pending entry is superseded.
//   Redirects while in BOOT are ignored.
//   Latency: a redirect with adv=1 appears on pc at the next edge (1 cycle).
//   Held redirect appears on pc at the edge ending the first adv=1 cycle.
//   pc changes only on adv=1 or reset; stall[STALL_W-1:1] are ignored here.
//   Reset mid-operation: immediate async return to reset values; pending entry is lost.
//   Arithmetic: the increment is a zero-extended constant; no overflow flag.
// STRUCTURE
//   Shared defines package: ChipEnable/ChipDisable, Branch/NotBranch, Stop/NoStop,
//   InstAddrBus width macro, FSM state encoding PCG_BOOT=1'b0, PCG_RUN=1'b1.
//   One natural sub-module: pc_redirect_buf, the pending-redirect holding register with priority merge.
//   Next-pc mux and FSM stay in pc_gen.
// TESTING
//   1. Reset release, stall=0, addr_ok=1 -> pc=bfc00000 during BOOT with ce=0.
//      Then ce=1; pc steps bfc00004, bfc00008.
//   2. branch_flag_i=1, target=80000100, adv=1 -> next pc=80000100.
//      Same cycle with flush_i=1, new_pc=bfc00380 -> pc=bfc00380.
//   3. stall[0]=1 for 3 cycles with branch to 80000200 in cycle 1 -> pc held.
//      Stall releases -> pc=80000200 one edge later; pend_vld=0.
//   4. inst_addr_ok_i=0 while pend holds flush bfc00380 and a branch 80000300 arrives -> branch dropped.
//      After addr_ok=1 -> pc=bfc00380.
//   5. ADDR_W=32, pc=fffffffc, sequential -> pc=00000000 (wrap).
//   6. rst=0 asserted between clock edges mid-run with pending redirect -> pc=bfc00000, ce=0 immediately.
//      Pending entry is not applied after release.

Source files
------------

// File: rtl/pc_gen_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pc_gen_pkg : shared fetch-stage defines and FSM encoding
// Revision   : 1.0
// ---------------------------------------------------------------------------
package pc_gen_pkg;

    localparam int INST_ADDR_W = 32;

    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic CHIP_DISABLE = 1'b0;
    localparam logic BRANCH       = 1'b1;
    localparam logic NOT_BRANCH   = 1'b0;
    localparam logic STOP         = 1'b1;
    localparam logic NO_STOP      = 1'b0;

    typedef enum logic [0:0] {
        PCG_BOOT = 1'b0,
        PCG_RUN  = 1'b1
    } pcg_state_t;

endpackage : pc_gen_pkg
`default_nettype wire

// File: rtl/pc_redirect_buf.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pc_redirect_buf : holds a redirect that arrived while the pc could not move
// Revision        : 1.0
// ---------------------------------------------------------------------------
module pc_redirect_buf
    import pc_gen_pkg::*;
#(
    parameter int ADDR_W = INST_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              adv,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc,
    input  logic              branch,
    input  logic [ADDR_W-1:0] branch_pc,
    output logic              pend_vld,
    output logic [ADDR_W-1:0] pend_pc,
    output logic              pend_is_flush
);

    logic              vld_next;
    logic [ADDR_W-1:0] pc_next;
    logic              is_flush_next;

    always_comb begin
        vld_next      = pend_vld;
        pc_next       = pend_pc;
        is_flush_next = pend_is_flush;
        if (run) begin
            if (adv) begin
                // Any advance consumes or supersedes the held entry.
                vld_next      = 1'b0;
                is_flush_next = 1'b0;
            end else if (flush) begin
                vld_next      = 1'b1;
                pc_next       = flush_pc;
                is_flush_next = 1'b1;
            end else if (branch == BRANCH && !(pend_vld && pend_is_flush)) begin
                vld_next      = 1'b1;
                pc_next       = branch_pc;
                is_flush_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_vld      <= 1'b0;
            pend_pc       <= '0;
            pend_is_flush <= 1'b0;
        end else begin
            pend_vld      <= vld_next;
            pend_pc       <= pc_next;
            pend_is_flush <= is_flush_next;
        end
    end

endmodule : pc_redirect_buf
`default_nettype wire

// File: rtl/pc_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pc_gen   : fetch-address generator with memory handshake and held redirects
// Revision : 1.0
// ---------------------------------------------------------------------------
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int               ADDR_W       = INST_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = 32'hbfc00000,
    parameter int               INST_BYTES   = 4,
    parameter int               STALL_W      = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush_i,
    input  logic [ADDR_W-1:0]  new_pc_i,
    input  logic               branch_flag_i,
    input  logic [ADDR_W-1:0]  branch_target_i,
    input  logic               inst_addr_ok_i,
    output logic [ADDR_W-1:0]  pc,
    output logic               ce,
    output logic               inst_req
);

    localparam logic [ADDR_W-1:0] INC = ADDR_W'(INST_BYTES);

    pcg_state_t        state;
    pcg_state_t        state_next;
    logic              run;
    logic              adv;
    logic              pend_vld;
    logic [ADDR_W-1:0] pend_pc;
    logic              pend_is_flush;
    logic [ADDR_W-1:0] pc_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= PCG_BOOT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ce         = CHIP_DISABLE;
        inst_req   = 1'b0;
        case (state)
            PCG_BOOT: begin
                state_next = PCG_RUN;
            end
            PCG_RUN: begin
                ce       = CHIP_ENABLE;
                inst_req = (stall[0] == NO_STOP);
            end
            default: begin
                state_next = PCG_BOOT;
            end
        endcase
    end

    assign run = (state == PCG_RUN);
    assign adv = run && (stall[0] == NO_STOP) && inst_addr_ok_i;

    pc_redirect_buf #(
        .ADDR_W (ADDR_W)
    ) u_redirect_buf (
        .clk           (clk),
        .rst           (rst),
        .run           (run),
        .adv           (adv),
        .flush         (flush_i),
        .flush_pc      (new_pc_i),
        .branch        (branch_flag_i),
        .branch_pc     (branch_target_i),
        .pend_vld      (pend_vld),
        .pend_pc       (pend_pc),
        .pend_is_flush (pend_is_flush)
    );

    always_comb begin
        pc_next = pc;
        if (adv) begin
            if (flush_i) begin
                pc_next = new_pc_i;
            end else if (pend_vld) begin
                pc_next = pend_pc;
            end else if (branch_flag_i == BRANCH) begin
                pc_next = branch_target_i;
            end else begin
                pc_next = pc + INC;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= RESET_VECTOR;
        end else begin
            pc <= pc_next;
        end
    end

endmodule : pc_gen
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pc_gen : directed self-checking bench for pc_gen
// Revision  : 1.0
// ---------------------------------------------------------------------------
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush_i;
    logic [31:0] new_pc_i;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        inst_addr_ok_i;
    logic [31:0] pc;
    logic        ce;
    logic        inst_req;

    int compared   = 0;
    int mismatched = 0;

    pc_gen dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .flush_i         (flush_i),
        .new_pc_i        (new_pc_i),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .inst_addr_ok_i  (inst_addr_ok_i),
        .pc              (pc),
        .ce              (ce),
        .inst_req        (inst_req)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; stall = '0; flush_i = 0; new_pc_i = '0;
        branch_flag_i = 0; branch_target_i = '0; inst_addr_ok_i = 1;
        tick(); tick();
        compared++; if (pc !== 32'hbfc00000) begin mismatched++; $display("FAIL reset_pc got %h want bfc00000", pc); end
        compared++; if (ce !== 1'b0) begin mismatched++; $display("FAIL reset_ce got %b want 0", ce); end
        rst = 1'b1;
        #1;
        compared++; if (pc !== 32'hbfc00000 || ce !== 1'b0 || inst_req !== 1'b0) begin
            mismatched++; $display("FAIL boot pc=%h ce=%b req=%b want bfc00000/0/0", pc, ce, inst_req); end
    endtask

    task automatic test_sequential();
        tick();
        compared++; if (pc !== 32'hbfc00000 || ce !== 1'b1 || inst_req !== 1'b1) begin
            mismatched++; $display("FAIL first_req pc=%h ce=%b req=%b want bfc00000/1/1", pc, ce, inst_req); end
        tick();
        compared++; if (pc !== 32'hbfc00004) begin mismatched++; $display("FAIL seq1 got %h want bfc00004", pc); end
        tick();
        compared++; if (pc !== 32'hbfc00008) begin mismatched++; $display("FAIL seq2 got %h want bfc00008", pc); end
    endtask

    task automatic test_branch_flush();
        branch_flag_i = 1; branch_target_i = 32'h80000100;
        tick();
        compared++; if (pc !== 32'h80000100) begin mismatched++; $display("FAIL branch got %h want 80000100", pc); end
        branch_target_i = 32'h80000500; flush_i = 1; new_pc_i = 32'hbfc00380;
        tick();
        branch_flag_i = 0; flush_i = 0;
        compared++; if (pc !== 32'hbfc00380) begin mismatched++; $display("FAIL flush_over_branch got %h want bfc00380", pc); end
    endtask

    task automatic test_stall_pending();
        stall = 6'b000001; branch_flag_i = 1; branch_target_i = 32'h80000200;
        tick();
        branch_flag_i = 0;
        tick(); tick();
        compared++; if (pc !== 32'hbfc00380 || inst_req !== 1'b0) begin
            mismatched++; $display("FAIL stall_hold pc=%h req=%b want bfc00380/0", pc, inst_req); end
        compared++; if (dut.pend_vld !== 1'b1) begin mismatched++; $display("FAIL stall_pend got %b want 1", dut.pend_vld); end
        stall = '0;
        tick();
        compared++; if (pc !== 32'h80000200) begin mismatched++; $display("FAIL stall_release got %h want 80000200", pc); end
        compared++; if (dut.pend_vld !== 1'b0) begin mismatched++; $display("FAIL pend_clear got %b want 0", dut.pend_vld); end
    endtask

    task automatic test_addr_ok_pending();
        inst_addr_ok_i = 0; flush_i = 1; new_pc_i = 32'hbfc00380;
        tick();
        flush_i = 0; branch_flag_i = 1; branch_target_i = 32'h80000300;
        tick();
        branch_flag_i = 0;
        compared++; if (pc !== 32'h80000200) begin mismatched++; $display("FAIL addr_ok_hold got %h want 80000200", pc); end
        inst_addr_ok_i = 1;
        tick();
        compared++; if (pc !== 32'hbfc00380) begin mismatched++; $display("FAIL pend_flush got %h want bfc00380", pc); end
        tick();
        compared++; if (pc !== 32'hbfc00384) begin mismatched++; $display("FAIL after_pend got %h want bfc00384", pc); end
    endtask

    task automatic test_wrap();
        flush_i = 1; new_pc_i = 32'hfffffffc;
        tick();
        flush_i = 0;
        compared++; if (pc !== 32'hfffffffc) begin mismatched++; $display("FAIL wrap_setup got %h want fffffffc", pc); end
        tick();
        compared++; if (pc !== 32'h00000000) begin mismatched++; $display("FAIL wrap got %h want 00000000", pc); end
    endtask

    task automatic test_reset_midrun();
        stall = 6'b000001; branch_flag_i = 1; branch_target_i = 32'h80000700;
        tick();
        branch_flag_i = 0;
        #2 rst = 1'b0;
        #1;
        compared++; if (pc !== 32'hbfc00000 || ce !== 1'b0 || inst_req !== 1'b0) begin
            mismatched++; $display("FAIL async_reset pc=%h ce=%b req=%b want bfc00000/0/0", pc, ce, inst_req); end
        compared++; if (dut.pend_vld !== 1'b0) begin mismatched++; $display("FAIL reset_pend got %b want 0", dut.pend_vld); end
        tick();
        rst = 1'b1; stall = '0;
        tick();
        compared++; if (pc !== 32'hbfc00000 || ce !== 1'b1) begin
            mismatched++; $display("FAIL rerun pc=%h ce=%b want bfc00000/1", pc, ce); end
        tick();
        compared++; if (pc !== 32'hbfc00004) begin mismatched++; $display("FAIL no_stale_pend got %h want bfc00004", pc); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch_flush();
        test_stall_pending();
        test_addr_ok_pending();
        test_wrap();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_pc_gen
`default_nettype wire
